// File: rtl/vedic_mac_accumulator.sv
// Operand sequencer and dot-product accumulator around the pipelined Vedic multiplier.
// Products are tagged through a shift register matching the multiplier latency.
module vedic_mac_accumulator #(
    parameter int MUL_LATENCY = 5,
    parameter int ACC_W       = 24
) (
    input  logic             clk1,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_a,
    input  logic [7:0]       in_b,
    input  logic             in_last,
    output logic [7:0]       mult_i,
    output logic [7:0]       mult_j,
    input  logic [15:0]      mult_z,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_acc,
    output logic [7:0]       out_count,
    output logic             out_ovf
);

    typedef enum logic [1:0] {
        RUN,
        DRAIN,
        HOLD
    } state_e;

    state_e                 state_q, state_d;
    logic                   ready_q, ready_d;
    logic                   valid_q, valid_d;
    logic [MUL_LATENCY-1:0] vld_sr_q, vld_sr_d;
    logic [MUL_LATENCY-1:0] last_sr_q, last_sr_d;
    logic [ACC_W-1:0]       acc_q, acc_d;
    logic [7:0]             cnt_q, cnt_d;
    logic                   ovf_q, ovf_d;
    logic [ACC_W-1:0]       out_acc_q, out_acc_d;
    logic [7:0]             out_count_q, out_count_d;
    logic                   out_ovf_q, out_ovf_d;

    logic                   fire;
    logic                   tap;
    logic                   tap_last;
    logic [ACC_W:0]         sum;
    logic [7:0]             cnt_inc;

    // Gate with rst so nothing is accepted in the reset cycle itself.
    assign in_ready  = ready_q & ~rst;
    assign fire      = in_valid & in_ready;
    assign mult_i    = fire ? in_a : 8'd0;
    assign mult_j    = fire ? in_b : 8'd0;
    assign out_valid = valid_q;
    assign out_acc   = out_acc_q;
    assign out_count = out_count_q;
    assign out_ovf   = out_ovf_q;

    assign tap      = vld_sr_q[MUL_LATENCY-1];
    assign tap_last = tap & last_sr_q[MUL_LATENCY-1];
    assign sum      = (ACC_W+1)'(acc_q) + (ACC_W+1)'(mult_z);
    assign cnt_inc  = (cnt_q == 8'hFF) ? 8'hFF : cnt_q + 8'd1;

    always_comb begin
        state_d     = state_q;
        ready_d     = ready_q;
        valid_d     = valid_q;
        vld_sr_d    = {vld_sr_q[MUL_LATENCY-2:0], fire};
        last_sr_d   = {last_sr_q[MUL_LATENCY-2:0], fire & in_last};
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        ovf_d       = ovf_q;
        out_acc_d   = out_acc_q;
        out_count_d = out_count_q;
        out_ovf_d   = out_ovf_q;

        if (tap_last) begin
            out_acc_d   = sum[ACC_W-1:0];
            out_count_d = cnt_inc;
            out_ovf_d   = ovf_q | sum[ACC_W];
            acc_d       = '0;
            cnt_d       = 8'd0;
            ovf_d       = 1'b0;
        end else if (tap) begin
            acc_d = sum[ACC_W-1:0];
            cnt_d = cnt_inc;
            ovf_d = ovf_q | sum[ACC_W];
        end

        case (state_q)
            RUN: begin
                if (fire && in_last) begin
                    state_d = DRAIN;
                    ready_d = 1'b0;
                end
            end
            DRAIN: begin
                if (tap_last) begin
                    state_d = HOLD;
                    valid_d = 1'b1;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = RUN;
                    valid_d = 1'b0;
                    ready_d = 1'b1;
                end
            end
            default: begin
                state_d = RUN;
                ready_d = 1'b1;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk1) begin
        if (rst) begin
            state_q     <= RUN;
            ready_q     <= 1'b1;
            valid_q     <= 1'b0;
            vld_sr_q    <= '0;
            last_sr_q   <= '0;
            acc_q       <= '0;
            cnt_q       <= 8'd0;
            ovf_q       <= 1'b0;
            out_acc_q   <= '0;
            out_count_q <= 8'd0;
            out_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ready_q     <= ready_d;
            valid_q     <= valid_d;
            vld_sr_q    <= vld_sr_d;
            last_sr_q   <= last_sr_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            out_acc_q   <= out_acc_d;
            out_count_q <= out_count_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

endmodule

// File: tb/tb_vedic_mac_accumulator.sv
// Randomized and directed bench for vedic_mac_accumulator with a behavioural
// multiplier pipeline and a dot-product reference model.
module tb_vedic_mac_accumulator;

    localparam int L     = 5;
    localparam int ACC_W = 24;

    logic             clk1 = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       in_a;
    logic [7:0]       in_b;
    logic             in_last;
    logic [7:0]       mult_i;
    logic [7:0]       mult_j;
    logic [15:0]      mult_z;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_acc;
    logic [7:0]       out_count;
    logic             out_ovf;

    vedic_mac_accumulator #(
        .MUL_LATENCY(L),
        .ACC_W      (ACC_W)
    ) u_dut (
        .clk1     (clk1),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_a     (in_a),
        .in_b     (in_b),
        .in_last  (in_last),
        .mult_i   (mult_i),
        .mult_j   (mult_j),
        .mult_z   (mult_z),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_acc  (out_acc),
        .out_count(out_count),
        .out_ovf  (out_ovf)
    );

    always #5 clk1 = ~clk1;

    // Multiplier model: product visible on mult_z L edges after the operands.
    logic [15:0] mpipe [L];
    always @(posedge clk1) begin
        mpipe[0] <= 16'(mult_i) * 16'(mult_j);
        for (int k = 1; k < L; k++) mpipe[k] <= mpipe[k-1];
    end
    assign mult_z = mpipe[L-1];

    int cyc = 0;
    always @(posedge clk1) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;
    int fire_cyc;

    logic [7:0] va[$];
    logic [7:0] vb[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] a, input logic [7:0] b, input logic l);
        @(negedge clk1);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_last  = l;
        #1;
        chk("in_ready", 32'(in_ready), 32'd1);
        chk("mult_ij", {16'd0, mult_i, mult_j}, {16'd0, a, b});
        fire_cyc = cyc;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk1);
            in_valid = 1'b0;
            in_last  = 1'b0;
            in_a     = $urandom_range(255);
            in_b     = $urandom_range(255);
        end
        #1;
        chk("mult_idle", {16'd0, mult_i, mult_j}, 32'd0);
    endtask

    task automatic get_result(input logic [ACC_W-1:0] e_acc, input int e_cnt,
                              input logic e_ovf, input int hold, input logic chk_lat);
        int t = 0;
        out_ready = (hold == 0);
        while (!out_valid && t < 400) begin
            @(negedge clk1);
            t++;
        end
        if (!out_valid) begin
            chk("result_timeout", 32'd0, 32'd1);
            return;
        end
        // Accept cycle counted as 0: out_valid is expected in cycle 6.
        if (chk_lat) chk("latency", 32'(cyc - fire_cyc), 32'(L + 1));
        chk("out_acc", 32'(out_acc), 32'(e_acc));
        chk("out_count", 32'(out_count), 32'(e_cnt));
        chk("out_ovf", 32'(out_ovf), 32'(e_ovf));
        chk("ready_in_hold", 32'(in_ready), 32'd0);
        repeat (hold) begin
            @(negedge clk1);
            chk("hold_valid", {31'd0, out_valid}, 32'd1);
            chk("hold_ready", 32'(in_ready), 32'd0);
            chk("hold_acc", {out_ovf, out_count, out_acc[22:0]},
                {e_ovf, 8'(e_cnt), e_acc[22:0]});
        end
        out_ready = 1'b1;
        @(negedge clk1);
        chk("valid_drop", 32'(out_valid), 32'd0);
        chk("ready_back", 32'(in_ready), 32'd1);
        chk("acc_stable", 32'(out_acc), 32'(e_acc));
    endtask

    // Reference: plain dot product, wrapped to ACC_W; all products are
    // nonnegative so a carry-out happened iff the true sum reached 2**ACC_W.
    task automatic run_vec(input int bub_pct, input int hold, input logic chk_lat);
        longint sum = 0;
        int     n   = va.size();
        for (int i = 0; i < n; i++) begin
            sum += longint'(va[i]) * longint'(vb[i]);
            if (i > 0 && $urandom_range(99) < bub_pct) idle($urandom_range(1, 2));
            push(va[i], vb[i], i == n - 1);
        end
        idle(1);
        get_result(ACC_W'(sum % (64'd1 << ACC_W)), (n > 255) ? 255 : n,
                   sum >= (64'd1 << ACC_W), hold, chk_lat);
        va.delete();
        vb.delete();
    endtask

    initial begin
        int stray;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = 8'd0;
        in_b      = 8'd0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk1);
        chk("ready_in_reset", 32'(in_ready), 32'd0);
        rst = 1'b0;
        @(negedge clk1);
        chk("rst_ready", 32'(in_ready), 32'd1);
        chk("rst_outs", {out_valid, out_ovf, out_count, out_acc[21:0]}, 32'd0);
        chk("rst_mult", {16'd0, mult_i, mult_j}, 32'd0);

        va = '{8'd255};
        vb = '{8'd255};
        run_vec(0, 0, 1'b1);

        // a={1,2,3,4}, b=2, two bubbles before element 3
        push(8'd1, 8'd2, 1'b0);
        push(8'd2, 8'd2, 1'b0);
        idle(2);
        push(8'd3, 8'd2, 1'b0);
        push(8'd4, 8'd2, 1'b1);
        idle(1);
        get_result(ACC_W'(20), 4, 1'b0, 0, 1'b1);

        va = '{8'd5, 8'd7};
        vb = '{8'd6, 8'd8};
        run_vec(0, 3, 1'b1);
        va = '{8'd10};
        vb = '{8'd10};
        run_vec(0, 0, 1'b1);

        for (int i = 0; i < 300; i++) begin
            va.push_back(8'd255);
            vb.push_back(8'd255);
        end
        run_vec(0, 1, 1'b1);
        va = '{8'd1};
        vb = '{8'd1};
        run_vec(0, 0, 1'b1);

        for (int i = 0; i < 300; i++) begin
            va.push_back(8'd1);
            vb.push_back(8'd1);
        end
        run_vec(10, 0, 1'b1);

        // reset in the middle of a vector
        push(8'd7, 8'd7, 1'b0);
        push(8'd7, 8'd7, 1'b0);
        push(8'd7, 8'd7, 1'b0);
        idle(2);
        @(negedge clk1);
        rst = 1'b1;
        #1;
        chk("ready_mid_rst", 32'(in_ready), 32'd0);
        @(negedge clk1);
        rst = 1'b0;
        #1;
        chk("mid_rst_outs", {out_valid, out_ovf, out_count, out_acc[21:0]}, 32'd0);
        chk("mid_rst_ready", 32'(in_ready), 32'd1);
        stray = 0;
        repeat (10) begin
            @(negedge clk1);
            if (out_valid) stray++;
        end
        chk("stray_valid", 32'(stray), 32'd0);
        va = '{8'd3};
        vb = '{8'd3};
        run_vec(0, 0, 1'b1);

        for (int v = 0; v < 25; v++) begin
            int n = $urandom_range(1, 12);
            for (int i = 0; i < n; i++) begin
                va.push_back(8'($urandom_range(255)));
                vb.push_back(8'($urandom_range(255)));
            end
            run_vec(30, $urandom_range(0, 3), 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
